tagger_timebase: RTL and testbench
==================================

# tagger_timebase

Parametrised free-running timebase for the tagger core: a WIDTH-bit fine counter with rollover pulse, extended by an EPOCH_WIDTH-bit rollover (epoch) counter. Adds count enable, synchronous clear for host resync, a sticky epoch-overflow flag and a one-deep valid/ready snapshot port. The snapshot port lets the readout path capture a coherent {epoch, counter} timestamp on request. It sits between the clock domain root and the tag formatter/readout FIFO.

## Interface
- WIDTH, 16, fine counter width (≥2)
- EPOCH_WIDTH, 32, epoch counter width (≥1)
- clk  in  1  sole clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  counter advances by 1 on each clk edge where high
- sync_clear  in  1  synchronous clear of counter, epoch, rollover, epoch_overflow
- counter  out  WIDTH  fine count
- rollover  out  1  high for exactly the cycle in which counter shows 0 as a result of wrapping
- epoch  out  EPOCH_WIDTH  number of wraps since reset/clear (modulo 2^EPOCH_WIDTH)
- epoch_overflow  out  1  sticky; set when epoch wraps
- snap_req  in  1  capture request, sampled each edge
- snap_valid  out  1  snapshot holding register full
- snap_ready  in  1  consumer accepts when snap_valid && snap_ready
- snap_time  out  EPOCH_WIDTH+WIDTH  {epoch, counter} captured
- snap_lost  out  1  one-cycle pulse: request dropped because slot full and not draining

## Operation
- Reset (rst_n low, asynchronous): every output 0; held until rst_n deasserts.
- Counting: enable high → counter <= counter+1 modulo 2^WIDTH. Enable low → counter, epoch hold and rollover <= 0.
- Wrap: increment from all-ones → counter 0, rollover 1 in that same registered cycle, epoch <= epoch+1. Rollover is 0 otherwise (including after reset and after clear, where counter is 0 without wrapping).
- Epoch wrap: epoch all-ones plus a wrap → epoch 0 and epoch_overflow <= 1. The flag stays set until sync_clear or reset.
- sync_clear has priority over enable. On the next edge counter=0, epoch=0, rollover=0, epoch_overflow=0. The snapshot slot is not affected.
- Snapshot: at an edge with snap_req high, the value captured is {epoch, counter} as visible on the outputs in that cycle (pre-increment, pre-clear).
  - Slot empty, or slot full and being consumed (snap_valid && snap_ready): load the slot. snap_valid is 1 next cycle.
  - Slot full and snap_ready low: the request is dropped. The slot keeps its old value and snap_lost pulses 1 the next cycle.
  - No request and a handshake occurs: snap_valid <= 0. snap_time holds its last value.
- snap_time is stable while snap_valid && !snap_ready.

## Timing
- Counter latency: the input is sampled at edge N and the result is visible after edge N.
- rollover is registered and coincident with counter==0 after a wrap, matching the legacy 16-bit counter semantics at default WIDTH.
- Snapshot: snap_req at edge N → snap_valid/snap_time valid after edge N. Throughput is 1 per cycle when snap_ready is tied high.
- A simultaneous snap_req and sync_clear captures the pre-clear value.
- A simultaneous wrap and snap_req captures {old epoch, all-ones}.
- rst_n asserted mid-operation clears everything immediately, including a pending snapshot.
- Deassertion of rst_n is synchronised upstream; the block itself makes no assumption about reset release alignment.

## Structure
- Package tagger_pkg: TAGGER_WIDTH_DEFAULT=16, TAGGER_EPOCH_WIDTH_DEFAULT=32, and the snapshot-word width function (EPOCH_WIDTH+WIDTH).
- Sub-module tagger_snapshot_slot: a one-deep valid/ready holding register, parametrised by data width. It takes load/data/ready and produces valid/data/lost. It is reused later by the per-channel tag capture.
- Top: counter/epoch/flag registers plus the capture mux.

## Test plan
Bench uses WIDTH=4, EPOCH_WIDTH=2 unless noted.
- Reset then enable=1 for 16 cycles → counter 0..15 then 0. rollover=1 only on that 0, and epoch=1.
- Enable=1 for 64 cycles from reset → epoch wraps to 0 on the 64th cycle and epoch_overflow=1 and stays 1. A subsequent sync_clear → all of counter, epoch, rollover and epoch_overflow are 0 next cycle.
- Enable toggles 1,0,1 around counter=15 → counter holds 15 with rollover=0 while disabled. The wrap occurs only on the enabled edge.
- snap_req one cycle at counter=7, epoch=2 with snap_ready=0 → snap_valid=1 and snap_time=0x27. A second snap_req → snap_lost pulse, snap_time stays 0x27. Raising snap_ready with a concurrent snap_req → the new value is loaded and snap_valid stays 1.
- snap_req and sync_clear together at counter=9, epoch=1 → snap_time=0x19 while counter and epoch are 0 next cycle. snap_req at counter=15 on a wrap edge → snap_time={1,15}.
- rst_n pulsed low mid-count with snap_valid=1 → all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/tagger_pkg.sv
// Shared constants, snapshot-slot state type and snapshot word width helper for the tagger core.
package tagger_pkg;

  localparam int unsigned TAGGER_WIDTH_DEFAULT       = 16;
  localparam int unsigned TAGGER_EPOCH_WIDTH_DEFAULT = 32;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Snapshot word is {epoch, counter}.
  function automatic int unsigned snap_width(input int unsigned width,
                                             input int unsigned epoch_width);
    return epoch_width + width;
  endfunction

endpackage

// File: rtl/tagger_timebase_if.sv
// Control, count and snapshot signals of the tagger timebase.
interface tagger_timebase_if
  import tagger_pkg::*;
#(
  parameter int unsigned WIDTH       = TAGGER_WIDTH_DEFAULT,
  parameter int unsigned EPOCH_WIDTH = TAGGER_EPOCH_WIDTH_DEFAULT
) ();

  localparam int unsigned SNAP_W = snap_width(WIDTH, EPOCH_WIDTH);

  logic                   enable;
  logic                   sync_clear;
  logic [WIDTH-1:0]       counter;
  logic                   rollover;
  logic [EPOCH_WIDTH-1:0] epoch;
  logic                   epoch_overflow;
  logic                   snap_req;
  logic                   snap_valid;
  logic                   snap_ready;
  logic [SNAP_W-1:0]      snap_time;
  logic                   snap_lost;

  modport master (
    output enable, sync_clear, snap_req, snap_ready,
    input  counter, rollover, epoch, epoch_overflow, snap_valid, snap_time, snap_lost
  );

  modport slave (
    input  enable, sync_clear, snap_req, snap_ready,
    output counter, rollover, epoch, epoch_overflow, snap_valid, snap_time, snap_lost
  );

endinterface

// File: rtl/tagger_snapshot_slot.sv
// One-deep valid/ready holding register; a load arriving while full and not draining is dropped and flagged.
module tagger_snapshot_slot
  import tagger_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_lost
);

  slot_state_t       r_state;
  slot_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              r_lost;
  logic              w_lost_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_lost  <= w_lost_nxt;
    end
  end

  // A full slot being drained this edge can take a new load in the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_lost_nxt  = 1'b0;
    case (r_state)
      SLOT_EMPTY: begin
        if (i_load) begin
          w_state_nxt = SLOT_FULL;
          w_data_nxt  = i_data;
        end
      end
      SLOT_FULL: begin
        if (i_load) begin
          if (i_ready) begin
            w_data_nxt = i_data;
          end else begin
            w_lost_nxt = 1'b1;
          end
        end else if (i_ready) begin
          w_state_nxt = SLOT_EMPTY;
        end
      end
    endcase
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_data  = r_data;
  assign o_lost  = r_lost;

endmodule

// File: rtl/tagger_timebase.sv
// Free-running fine counter extended by an epoch counter, with sticky epoch overflow and a snapshot port.
module tagger_timebase
  import tagger_pkg::*;
#(
  parameter int unsigned WIDTH       = TAGGER_WIDTH_DEFAULT,
  parameter int unsigned EPOCH_WIDTH = TAGGER_EPOCH_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  tagger_timebase_if.slave bus
);

  localparam int unsigned SNAP_W = snap_width(WIDTH, EPOCH_WIDTH);

  logic [WIDTH-1:0]       r_counter;
  logic [EPOCH_WIDTH-1:0] r_epoch;
  logic                   r_rollover;
  logic                   r_epoch_overflow;

  logic                   w_wrap;
  logic                   w_epoch_wrap;
  logic [SNAP_W-1:0]      w_capture;
  logic                   w_snap_valid;
  logic [SNAP_W-1:0]      w_snap_time;
  logic                   w_snap_lost;

  assign w_wrap       = bus.enable && (r_counter == '1);
  assign w_epoch_wrap = w_wrap && (r_epoch == '1);

  // Clear wins over counting; rollover marks only a 0 reached by wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_counter        <= '0;
      r_epoch          <= '0;
      r_rollover       <= 1'b0;
      r_epoch_overflow <= 1'b0;
    end else if (bus.sync_clear) begin
      r_counter        <= '0;
      r_epoch          <= '0;
      r_rollover       <= 1'b0;
      r_epoch_overflow <= 1'b0;
    end else if (bus.enable) begin
      r_counter  <= r_counter + WIDTH'(1);
      r_rollover <= w_wrap;
      if (w_wrap) begin
        r_epoch <= r_epoch + EPOCH_WIDTH'(1);
      end
      if (w_epoch_wrap) begin
        r_epoch_overflow <= 1'b1;
      end
    end else begin
      r_rollover <= 1'b0;
    end
  end

  // Capture the currently visible (pre-increment, pre-clear) timestamp.
  assign w_capture = {r_epoch, r_counter};

  tagger_snapshot_slot #(
    .DATA_W (SNAP_W)
  ) u_snap_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (bus.snap_req),
    .i_data  (w_capture),
    .i_ready (bus.snap_ready),
    .o_valid (w_snap_valid),
    .o_data  (w_snap_time),
    .o_lost  (w_snap_lost)
  );

  assign bus.counter        = r_counter;
  assign bus.epoch          = r_epoch;
  assign bus.rollover       = r_rollover;
  assign bus.epoch_overflow = r_epoch_overflow;
  assign bus.snap_valid     = w_snap_valid;
  assign bus.snap_time      = w_snap_time;
  assign bus.snap_lost      = w_snap_lost;

endmodule

// File: tb/tb_tagger_timebase.sv
// Self-checking bench for tagger_timebase at WIDTH=4, EPOCH_WIDTH=2.
module tb_tagger_timebase;

  localparam int unsigned W = 4;
  localparam int unsigned E = 2;

  logic clk;
  logic rst_n;

  tagger_timebase_if #(.WIDTH(W), .EPOCH_WIDTH(E)) bus ();

  tagger_timebase #(.WIDTH(W), .EPOCH_WIDTH(E)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: total enabled ticks since reset/clear, plus the snapshot slot.
  int         m_ticks;
  bit         m_roll;
  bit         m_full;
  logic [5:0] m_snap;
  bit         m_lost;

  typedef struct {
    logic en, clr, req, rdy;
    logic [3:0] cnt;
    logic roll;
    logic [1:0] ep;
    logic ovf, vld;
    logic [5:0] tm;
    logic lost;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ticks = 0;
    m_roll  = 0;
    m_full  = 0;
    m_snap  = '0;
    m_lost  = 0;
  endtask

  task automatic model_step(input logic en, input logic clr, input logic req, input logic rdy);
    logic [5:0] cur;
    cur = 6'(m_ticks % 64);
    if (req) begin
      if (!m_full || rdy) begin
        m_full = 1;
        m_snap = cur;
        m_lost = 0;
      end else begin
        m_lost = 1;
      end
    end else begin
      m_lost = 0;
      if (m_full && rdy) m_full = 0;
    end
    if (clr) begin
      m_ticks = 0;
      m_roll  = 0;
    end else if (en) begin
      m_ticks++;
      m_roll = (m_ticks % 16 == 0);
    end else begin
      m_roll = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".counter"},  64'(bus.counter),        64'(m_ticks % 16));
    chk({tag, ".rollover"}, 64'(bus.rollover),       64'(m_roll));
    chk({tag, ".epoch"},    64'(bus.epoch),          64'((m_ticks / 16) % 4));
    chk({tag, ".ovf"},      64'(bus.epoch_overflow), 64'(m_ticks >= 64));
    chk({tag, ".valid"},    64'(bus.snap_valid),     64'(m_full));
    chk({tag, ".time"},     64'(bus.snap_time),      64'(m_snap));
    chk({tag, ".lost"},     64'(bus.snap_lost),      64'(m_lost));
  endtask

  task automatic drive(input logic en, input logic clr, input logic req, input logic rdy);
    bus.enable     = en;
    bus.sync_clear = clr;
    bus.snap_req   = req;
    bus.snap_ready = rdy;
  endtask

  task automatic cycle(input logic en, input logic clr, input logic req, input logic rdy,
                       input string tag);
    drive(en, clr, req, rdy);
    model_step(en, clr, req, rdy);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run_en(input int n, input logic rdy, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, rdy, tag);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    check_all("reset");
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    check_all("por");
    @(negedge clk);
    do_reset();

    // Table of hand-derived vectors starting from reset.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 2'd0, 1'b0, 1'b0, 6'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 2'd0, 1'b0, 1'b1, 6'h01, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 2'd0, 1'b0, 1'b1, 6'h01, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0, 6'h01, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 6'h02, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 2'd0, 1'b0, 1'b1, 6'h02, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b1, 6'h01, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 2'd0, 1'b0, 1'b1, 6'h01, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].req, vecs[i].rdy);
      model_step(vecs[i].en, vecs[i].clr, vecs[i].req, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d.counter", i), 64'(bus.counter),        64'(vecs[i].cnt));
      chk($sformatf("vec%0d.rollover", i), 64'(bus.rollover),      64'(vecs[i].roll));
      chk($sformatf("vec%0d.epoch", i),   64'(bus.epoch),          64'(vecs[i].ep));
      chk($sformatf("vec%0d.ovf", i),     64'(bus.epoch_overflow), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d.valid", i),   64'(bus.snap_valid),     64'(vecs[i].vld));
      chk($sformatf("vec%0d.time", i),    64'(bus.snap_time),      64'(vecs[i].tm));
      chk($sformatf("vec%0d.lost", i),    64'(bus.snap_lost),      64'(vecs[i].lost));
    end

    // 16 enabled cycles: one wrap.
    do_reset();
    run_en(16, 1'b0, "wrap16");
    chk("wrap16.cnt0",  64'(bus.counter),  64'd0);
    chk("wrap16.roll1", 64'(bus.rollover), 64'd1);
    chk("wrap16.ep1",   64'(bus.epoch),    64'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "wrap16.after");
    chk("wrap16.roll0", 64'(bus.rollover), 64'd0);

    // 64 enabled cycles: epoch wraps and overflow sticks until clear.
    do_reset();
    run_en(64, 1'b0, "wrap64");
    chk("wrap64.ep0",  64'(bus.epoch),          64'd0);
    chk("wrap64.ovf1", 64'(bus.epoch_overflow), 64'd1);
    run_en(5, 1'b0, "wrap64.hold");
    chk("wrap64.ovf_sticky", 64'(bus.epoch_overflow), 64'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, "clear");
    chk("clear.cnt",  64'(bus.counter),        64'd0);
    chk("clear.ep",   64'(bus.epoch),          64'd0);
    chk("clear.roll", 64'(bus.rollover),       64'd0);
    chk("clear.ovf",  64'(bus.epoch_overflow), 64'd0);

    // Enable toggled around counter=15.
    do_reset();
    run_en(15, 1'b0, "tog.pre");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "tog.off");
    chk("tog.off.cnt15", 64'(bus.counter),  64'd15);
    chk("tog.off.roll0", 64'(bus.rollover), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "tog.on");
    chk("tog.on.cnt0",  64'(bus.counter),  64'd0);
    chk("tog.on.roll1", 64'(bus.rollover), 64'd1);

    // Snapshot at counter 7, epoch 2 with consumer stalled.
    do_reset();
    run_en(39, 1'b0, "snap.pre");
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "snap.first");
    chk("snap.first.valid", 64'(bus.snap_valid), 64'd1);
    chk("snap.first.time",  64'(bus.snap_time),  64'h27);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "snap.drop");
    chk("snap.drop.lost", 64'(bus.snap_lost), 64'd1);
    chk("snap.drop.time", 64'(bus.snap_time), 64'h27);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, "snap.reload");
    chk("snap.reload.time",  64'(bus.snap_time),  64'h29);
    chk("snap.reload.valid", 64'(bus.snap_valid), 64'd1);
    chk("snap.reload.lost",  64'(bus.snap_lost),  64'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "snap.drain");

    // Snapshot with clear, then snapshot on a wrap edge.
    do_reset();
    run_en(25, 1'b0, "sclr.pre");
    cycle(1'b1, 1'b1, 1'b1, 1'b1, "sclr");
    chk("sclr.time", 64'(bus.snap_time), 64'h19);
    chk("sclr.cnt",  64'(bus.counter),   64'd0);
    chk("sclr.ep",   64'(bus.epoch),     64'd0);
    run_en(31, 1'b1, "swrap.pre");
    cycle(1'b1, 1'b0, 1'b1, 1'b1, "swrap");
    chk("swrap.time", 64'(bus.snap_time), 64'h1F);
    chk("swrap.roll", 64'(bus.rollover),  64'd1);

    // Asynchronous reset between edges with a pending snapshot.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "ares.pre");
    run_en(3, 1'b0, "ares.count");
    #2;
    rst_n = 1'b0;
    #1;
    chk("ares.cnt",   64'(bus.counter),        64'd0);
    chk("ares.ep",    64'(bus.epoch),          64'd0);
    chk("ares.roll",  64'(bus.rollover),       64'd0);
    chk("ares.ovf",   64'(bus.epoch_overflow), 64'd0);
    chk("ares.valid", 64'(bus.snap_valid),     64'd0);
    chk("ares.time",  64'(bus.snap_time),      64'd0);
    chk("ares.lost",  64'(bus.snap_lost),      64'd0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    check_all("ares.post");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 79) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
